fpu_issue: RTL and testbench
============================

FPU_ISSUE -- requirements
Module: fpu_issue

Interface
REQ-001 SHALL have parameter INT_LAT, default 3, meaning the cycle count from an accepted FPU issue (fpu_is_legl=1) to valid fpu_to_intreg data; legal range 2..6.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock
- rstn  in  1  synchronous active-low reset
- in_valid  in  1  decoded FP instruction offered
- in_inst  in  32  FP instruction word
- in_rs1_val  in  32  integer rs1 operand
- in_ready  out  1  instruction accepted this cycle
- flush  in  1  kill the un-issued slot
- fpu_inst  out  32  instruction to FPU
- fpu_is_legl  out  1  issue qualifier to FPU
- fpu_from_intreg  out  32  integer operand to FPU
- fpu_hazard  in  1  FPU stall request for fpu_inst
- fpu_to_intreg  in  32  FPU integer-result bus
- wb_en  out  1  integer regfile write enable
- wb_rd  out  5  integer write index
- wb_data  out  32  integer write data
- int_rs1  in  5  integer consumer source 1
- int_rs2  in  5  integer consumer source 2
- int_busy  out  1  consumer must stall

Function
REQ-003 SHALL hold one issue slot {valid, inst, rs1_val}, registered.
REQ-004 SHALL drive fpu_inst and fpu_from_intreg from the slot; fpu_inst is 32'h0 when the slot is empty.
REQ-005 SHALL assert fpu_is_legl = slot_valid & ~fpu_hazard & ~flush.
REQ-006 SHALL issue when fpu_is_legl=1; the slot then loads in_inst if in_valid, else empties.
REQ-007 SHALL assert in_ready = ~slot_valid | (fpu_is_legl); combinational.
REQ-008 SHALL hold the slot unchanged while fpu_hazard=1; fpu_hazard is ignored when the slot is empty.
REQ-009 SHALL, on flush=1, empty the slot at the clock edge, not issue, and drop any same-cycle in_valid (in_ready=0 during flush).
REQ-010 SHALL classify an issued inst as int-writing when opcode=7'b1010011 and inst[31:27] is in {5'b10100 fcmp, 5'b11000 fcvt.w.s, 5'b11100 fmv.x.w}.
REQ-011 SHALL push {int_wr, rd=inst[11:7]} into an INT_LAT-deep tracker shift register on every cycle; a non-issue cycle pushes int_wr=0.
REQ-012 SHALL, when the tracker entry at depth INT_LAT has int_wr=1 and rd!=0, assert wb_en=1, wb_rd=rd, wb_data=fpu_to_intreg in that same cycle.
REQ-013 SHALL, otherwise, drive wb_en=0, wb_rd=0, wb_data=0.
REQ-014 SHALL assert int_busy when nonzero int_rs1 or int_rs2 equals the rd of any int_wr tracker entry at depth 1..INT_LAT, or of a valid int-writing slot.
REQ-015 SHALL not mask, drop, or alter in-flight tracker entries when flush=1.
REQ-016 SHALL give back-to-back issues independent tracker entries, allowing one issue and one writeback per cycle.

Reset
REQ-017 SHALL, while rstn=0 at a clock edge, clear slot_valid and all tracker int_wr bits.
REQ-018 SHALL, after reset, present in_ready=1, fpu_is_legl=0, fpu_inst=0, wb_en=0, and int_busy=0.
REQ-019 SHALL discard an in-flight instruction when reset is asserted mid-operation; no wb_en follows reset release.

Configuration
REQ-020 SHALL implement macro FPU_ISSUE_WB_BYPASS_EN.
- Defined: int_busy ignores the depth-INT_LAT entry; the consumer takes its operand from wb_data via the same-cycle writeback.
- Undefined: the depth-INT_LAT entry also raises int_busy, per REQ-014.

Verification
REQ-021 SHALL cover these directed scenarios with INT_LAT=3:
- Issue fcvt.w.s with rd=5, fpu_to_intreg=32'h0000002A at cycle t+3 -> wb_en=1, wb_rd=5, wb_data=32'h2A at exactly t+3; wb_en=0 at t+2 and t+4.
- Slot full, fpu_hazard=1 for 2 cycles, in_valid=1 -> fpu_is_legl=0 and in_ready=0 for 2 cycles; fpu_inst stable; issue on the 3rd cycle with in_ready=1.
- fcmp with rd=0 -> no wb_en; int_busy stays 0 for int_rs1=0.
- int_rs1=7 with fmv.x.w rd=7 in flight -> int_busy=1 from slot load until depth 2 (bypass build) or depth 3 (no bypass); 0 after.
- flush=1 with slot full and in_valid=1 -> no issue; slot empty next cycle; an older in-flight fcvt still writes back.
- rstn=0 for 1 cycle between issue and writeback -> no wb_en afterwards; in_ready=1, int_busy=0.

Source files
------------

// File: rtl/fpu_issue.sv
// fpu_issue: single-slot issue stage between the integer pipe and the FPU.
// Holds one decoded FP instruction, presents it to the FPU, and tracks
// FP->integer results (fcmp, fcvt.w.s, fmv.x.w) through an INT_LAT-deep
// shift register so the integer regfile write lands exactly INT_LAT cycles
// after issue. The tracker also drives the integer-side hazard (int_busy).
//
// Optional feature macro: FPU_ISSUE_WB_BYPASS_EN
//   defined   -> the entry at depth INT_LAT does not raise int_busy; the
//                consumer picks its operand off wb_data in that same cycle.
//   undefined -> every tracker entry depth 1..INT_LAT raises int_busy.
//
// Handshake: the slot accepts in_inst when in_valid & in_ready. in_ready is
// high when the slot is empty or is issuing this cycle, and never during
// flush. The FPU takes fpu_inst when fpu_is_legl is high; fpu_hazard holds
// the slot in place.
//
// INT_LAT is intended for the range 2..6.

module fpu_issue #(
  parameter int INT_LAT = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_rs1_val,
  output logic        in_ready,
  input  logic        flush,
  output logic [31:0] fpu_inst,
  output logic        fpu_is_legl,
  output logic [31:0] fpu_from_intreg,
  input  logic        fpu_hazard,
  input  logic [31:0] fpu_to_intreg,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  input  logic [4:0]  int_rs1,
  input  logic [4:0]  int_rs2,
  output logic        int_busy
);

`ifdef FPU_ISSUE_WB_BYPASS_EN
  // The writeback-cycle entry is forwarded, so it need not stall the consumer.
  localparam int BUSY_TOP = INT_LAT - 1;
`else
  localparam int BUSY_TOP = INT_LAT;
`endif

  // OP-FP instructions whose result goes to the integer register file.
  function automatic logic is_int_wr(input logic [31:0] inst);
    logic [4:0] f5;
    f5 = inst[31:27];
    return (inst[6:0] == 7'b1010011) &&
           ((f5 == 5'b10100) || (f5 == 5'b11000) || (f5 == 5'b11100));
  endfunction

  // ---------------------------------------------------------------------
  // Issue slot
  // ---------------------------------------------------------------------
  logic        slot_valid_q, slot_valid_d;
  logic [31:0] slot_inst_q,  slot_inst_d;
  logic [31:0] slot_rs1_q,   slot_rs1_d;
  logic        slot_int_wr;
  logic        accept;

  assign slot_int_wr     = is_int_wr(slot_inst_q);
  assign fpu_is_legl     = slot_valid_q & ~fpu_hazard & ~flush;
  assign in_ready        = ~flush & (~slot_valid_q | fpu_is_legl);
  assign accept          = in_valid & in_ready;
  assign fpu_inst        = slot_valid_q ? slot_inst_q : 32'h0;
  assign fpu_from_intreg = slot_rs1_q;

  // Slot next state: flush empties, accept loads, a bare issue empties.
  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_inst_d  = slot_inst_q;
    slot_rs1_d   = slot_rs1_q;
    if (flush) begin
      slot_valid_d = 1'b0;
    end else if (accept) begin
      slot_valid_d = 1'b1;
      slot_inst_d  = in_inst;
      slot_rs1_d   = in_rs1_val;
    end else if (fpu_is_legl) begin
      slot_valid_d = 1'b0;
    end
  end

  // Slot registers; only the valid bit needs reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      slot_valid_q <= 1'b0;
    end else begin
      slot_valid_q <= slot_valid_d;
    end
    slot_inst_q <= slot_inst_d;
    slot_rs1_q  <= slot_rs1_d;
  end

  // ---------------------------------------------------------------------
  // Integer-result tracker: entry k describes the issue k cycles ago.
  // ---------------------------------------------------------------------
  logic [INT_LAT:1] trk_wr_q, trk_wr_d;
  logic [4:0]       trk_rd_q [1:INT_LAT];
  logic [4:0]       trk_rd_d [1:INT_LAT];

  // Shift every cycle; a non-issue cycle inserts an empty entry.
  always_comb begin
    trk_wr_d[1] = fpu_is_legl & slot_int_wr;
    trk_rd_d[1] = slot_inst_q[11:7];
    for (int k = 2; k <= INT_LAT; k++) begin
      trk_wr_d[k] = trk_wr_q[k-1];
      trk_rd_d[k] = trk_rd_q[k-1];
    end
  end

  // Tracker registers; flush never touches in-flight entries.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      trk_wr_q <= '0;
    end else begin
      trk_wr_q <= trk_wr_d;
    end
    for (int k = 1; k <= INT_LAT; k++) begin
      trk_rd_q[k] <= trk_rd_d[k];
    end
  end

  // ---------------------------------------------------------------------
  // Writeback from the oldest entry; rd=0 writes are suppressed.
  // ---------------------------------------------------------------------
  logic wb_hit;
  assign wb_hit = trk_wr_q[INT_LAT] & (trk_rd_q[INT_LAT] != 5'd0);

  // Writeback outputs are forced to zero when no write is due.
  always_comb begin
    wb_en   = 1'b0;
    wb_rd   = 5'd0;
    wb_data = 32'h0;
    if (wb_hit) begin
      wb_en   = 1'b1;
      wb_rd   = trk_rd_q[INT_LAT];
      wb_data = fpu_to_intreg;
    end
  end

  // ---------------------------------------------------------------------
  // Consumer hazard: a nonzero source matching any pending integer rd.
  // ---------------------------------------------------------------------
  function automatic logic src_match(input logic [4:0] rd,
                                     input logic [4:0] rs1,
                                     input logic [4:0] rs2);
    return ((rs1 != 5'd0) && (rs1 == rd)) || ((rs2 != 5'd0) && (rs2 == rd));
  endfunction

  // OR together the slot and every tracked entry up to BUSY_TOP.
  always_comb begin
    int_busy = slot_valid_q & slot_int_wr &
               src_match(slot_inst_q[11:7], int_rs1, int_rs2);
    for (int k = 1; k <= BUSY_TOP; k++) begin
      int_busy = int_busy | (trk_wr_q[k] & src_match(trk_rd_q[k], int_rs1, int_rs2));
    end
  end

endmodule

// File: tb/tb_fpu_issue.sv
// tb_fpu_issue: directed bench for fpu_issue with INT_LAT=3. Writebacks are
// predicted into exp_q as instructions are offered and retired by a
// negedge monitor that also demands idle writeback outputs in all other
// cycles.

module tb_fpu_issue;

  localparam int LAT = 3;
  localparam logic [4:0] F_ADD = 5'b00000;
  localparam logic [4:0] F_CMP = 5'b10100;
  localparam logic [4:0] F_CVT = 5'b11000;
  localparam logic [4:0] F_MV  = 5'b11100;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_rs1_val;
  logic        in_ready;
  logic        flush;
  logic [31:0] fpu_inst;
  logic        fpu_is_legl;
  logic [31:0] fpu_from_intreg;
  logic        fpu_hazard;
  logic [31:0] fpu_to_intreg;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  int_rs1;
  logic [4:0]  int_rs2;
  logic        int_busy;

  fpu_issue #(.INT_LAT(LAT)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_inst(in_inst), .in_rs1_val(in_rs1_val),
    .in_ready(in_ready), .flush(flush),
    .fpu_inst(fpu_inst), .fpu_is_legl(fpu_is_legl),
    .fpu_from_intreg(fpu_from_intreg), .fpu_hazard(fpu_hazard),
    .fpu_to_intreg(fpu_to_intreg),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .int_rs1(int_rs1), .int_rs2(int_rs2), .int_busy(int_busy)
  );

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] cyc = 32'd0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // FPU result bus: a per-cycle signature unless one cycle is overridden.
  logic [31:0] ovr_cyc;
  logic [31:0] ovr_val;
  assign fpu_to_intreg = (cyc == ovr_cyc) ? ovr_val : {16'hF00D, cyc[15:0]};

  // ---------------- scoreboard state ----------------
  logic [68:0] exp_q[$];  // {cycle, rd, data}
  int total = 0;
  int bad = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] data_at(input logic [31:0] c);
    return (c == ovr_cyc) ? ovr_val : {16'hF00D, c[15:0]};
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] f5, input logic [4:0] rd,
                                     input logic [6:0] op);
    return {f5, 2'b00, 5'd2, 5'd1, 3'b000, rd, op};
  endfunction

  task automatic push_wb(input logic [31:0] c, input logic [4:0] rd);
    exp_q.push_back({c, rd, data_at(c)});
  endtask

  // Writeback monitor: retire the due entry, otherwise require idle outputs.
  always @(negedge clk) begin
    if (mon_en && rstn) begin
      if (exp_q.size() > 0 && exp_q[0][68:37] == cyc) begin
        chk("wb_due", {26'd0, wb_en, wb_rd, wb_data},
            {26'd0, 1'b1, exp_q[0][36:32], exp_q[0][31:0]});
        void'(exp_q.pop_front());
      end else begin
        chk("wb_idle", {26'd0, wb_en, wb_rd, wb_data}, 64'd0);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    flush      = 1'b0;
    fpu_hazard = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] c0;
  logic [31:0] ia, ib, id_keep;
  logic [4:0]  rrd, f;
  logic [6:0]  op;
  logic        busy_exp [0:5];

  initial begin
    rstn = 1'b0; idle();
    in_inst = 32'h0; in_rs1_val = 32'h0; int_rs1 = 5'd0; int_rs2 = 5'd0;
    ovr_cyc = 32'hFFFF_FFFF; ovr_val = 32'h0;
    repeat (3) nxt();
    rstn = 1'b1; mon_en = 1'b1;
    @(negedge clk);
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_legl",  {63'd0, fpu_is_legl}, 64'd0);
    chk("rst_inst",  {32'd0, fpu_inst}, 64'd0);
    chk("rst_wb_en", {63'd0, wb_en}, 64'd0);
    chk("rst_busy",  {63'd0, int_busy}, 64'd0);

    // fcvt.w.s rd=5: issue one cycle after offer, write 0x2A LAT cycles later.
    nxt(); c0 = cyc;
    in_valid = 1'b1; in_inst = mk(F_CVT, 5'd5, 7'b1010011); in_rs1_val = 32'h1111_2222;
    ovr_cyc = c0 + 32'd1 + LAT; ovr_val = 32'h0000_002A;
    push_wb(c0 + 32'd1 + LAT, 5'd5);
    @(negedge clk);
    chk("s1_ready", {63'd0, in_ready}, 64'd1);
    nxt(); idle();
    @(negedge clk);
    chk("s1_legl", {63'd0, fpu_is_legl}, 64'd1);
    chk("s1_inst", {32'd0, fpu_inst}, {32'd0, mk(F_CVT, 5'd5, 7'b1010011)});
    chk("s1_rs1",  {32'd0, fpu_from_intreg}, 64'h1111_2222);
    repeat (5) nxt();

    // Hazard holds a full slot for two cycles while a new offer waits.
    ia = mk(F_ADD, 5'd3, 7'b1010011); ib = mk(F_CVT, 5'd12, 7'b1010011);
    nxt(); in_valid = 1'b1; in_inst = ia;
    @(negedge clk);
    chk("s2_load_ready", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 2; i++) begin
      nxt(); fpu_hazard = 1'b1; in_valid = 1'b1; in_inst = ib;
      @(negedge clk);
      chk("s2_hz_legl",  {63'd0, fpu_is_legl}, 64'd0);
      chk("s2_hz_ready", {63'd0, in_ready}, 64'd0);
      chk("s2_hz_inst",  {32'd0, fpu_inst}, {32'd0, ia});
    end
    nxt(); fpu_hazard = 1'b0;
    push_wb(cyc + 32'd1 + LAT, 5'd12);
    @(negedge clk);
    chk("s2_go_legl",  {63'd0, fpu_is_legl}, 64'd1);
    chk("s2_go_ready", {63'd0, in_ready}, 64'd1);
    chk("s2_go_inst",  {32'd0, fpu_inst}, {32'd0, ia});
    nxt(); idle();
    @(negedge clk);
    chk("s2_b_inst", {32'd0, fpu_inst}, {32'd0, ib});
    chk("s2_b_legl", {63'd0, fpu_is_legl}, 64'd1);
    repeat (5) nxt();

    // fcmp to x0: no writeback and no stall on source x0.
    nxt(); in_valid = 1'b1; in_inst = mk(F_CMP, 5'd0, 7'b1010011);
    @(negedge clk);
    chk("s3_busy0", {63'd0, int_busy}, 64'd0);
    nxt(); idle();
    @(negedge clk);
    chk("s3_legl", {63'd0, fpu_is_legl}, 64'd1);
    chk("s3_busy1", {63'd0, int_busy}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      nxt(); @(negedge clk);
      chk("s3_busy_t", {63'd0, int_busy}, 64'd0);
    end

    // fmv.x.w rd=7 in flight against a consumer reading x7.
`ifdef FPU_ISSUE_WB_BYPASS_EN
    busy_exp = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
`else
    busy_exp = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
    for (int k = 0; k < 6; k++) begin
      nxt();
      if (k[0]) begin int_rs1 = 5'd3; int_rs2 = 5'd7; end
      else      begin int_rs1 = 5'd7; int_rs2 = 5'd3; end
      if (k == 0) begin
        in_valid = 1'b1; in_inst = mk(F_MV, 5'd7, 7'b1010011);
        push_wb(cyc + 32'd1 + LAT, 5'd7);
      end else begin
        idle();
      end
      @(negedge clk);
      chk("s4_busy", {63'd0, int_busy}, {63'd0, busy_exp[k]});
    end
    nxt(); int_rs1 = 5'd0; int_rs2 = 5'd0;
    repeat (3) nxt();

    // Flush drops the waiting slot and the same-cycle offer, not the older issue.
    id_keep = mk(F_CVT, 5'd21, 7'b1010011);
    nxt(); in_valid = 1'b1; in_inst = mk(F_CVT, 5'd20, 7'b1010011);
    push_wb(cyc + 32'd1 + LAT, 5'd20);
    @(negedge clk);
    chk("s5_ready0", {63'd0, in_ready}, 64'd1);
    nxt(); in_valid = 1'b1; in_inst = id_keep;
    @(negedge clk);
    chk("s5_legl1", {63'd0, fpu_is_legl}, 64'd1);
    nxt(); flush = 1'b1; in_valid = 1'b1; in_inst = mk(F_CVT, 5'd22, 7'b1010011);
    @(negedge clk);
    chk("s5_fl_legl",  {63'd0, fpu_is_legl}, 64'd0);
    chk("s5_fl_ready", {63'd0, in_ready}, 64'd0);
    chk("s5_fl_inst",  {32'd0, fpu_inst}, {32'd0, id_keep});
    nxt(); idle();
    @(negedge clk);
    chk("s5_empty_inst",  {32'd0, fpu_inst}, 64'd0);
    chk("s5_empty_legl",  {63'd0, fpu_is_legl}, 64'd0);
    chk("s5_empty_ready", {63'd0, in_ready}, 64'd1);
    repeat (5) nxt();

    // Reset between issue and writeback kills the pending write.
    nxt(); in_valid = 1'b1; in_inst = mk(F_CVT, 5'd25, 7'b1010011);
    push_wb(cyc + 32'd1 + LAT, 5'd25);
    nxt(); idle(); int_rs1 = 5'd25;
    @(negedge clk);
    chk("s6_legl", {63'd0, fpu_is_legl}, 64'd1);
    chk("s6_busy", {63'd0, int_busy}, 64'd1);
    nxt(); rstn = 1'b0; exp_q.delete();
    nxt(); rstn = 1'b1;
    @(negedge clk);
    chk("s6_ready", {63'd0, in_ready}, 64'd1);
    chk("s6_busy0", {63'd0, int_busy}, 64'd0);
    chk("s6_legl0", {63'd0, fpu_is_legl}, 64'd0);
    repeat (4) nxt();
    int_rs1 = 5'd0;

    // Back-to-back random stream: one issue and one writeback every cycle.
    for (int i = 0; i < 24; i++) begin
      nxt();
      case ($urandom_range(0, 4))
        0: f = F_ADD;
        1: f = F_CMP;
        2: f = F_CVT;
        3: f = F_MV;
        default: f = F_CVT;
      endcase
      op = ($urandom_range(0, 5) == 0) ? 7'b1000011 : 7'b1010011;
      rrd = 5'($urandom_range(0, 31));
      in_valid = 1'b1; in_inst = mk(f, rrd, op); in_rs1_val = $urandom;
      if (op == 7'b1010011 && (f == F_CMP || f == F_CVT || f == F_MV) && rrd != 5'd0)
        push_wb(cyc + 32'd1 + LAT, rrd);
      @(negedge clk);
      chk("s7_ready", {63'd0, in_ready}, 64'd1);
      if (i > 0) chk("s7_legl", {63'd0, fpu_is_legl}, 64'd1);
    end
    nxt(); idle();

    // Drain, bounded.
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) nxt();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    repeat (2) nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
